// File: rtl/clk_rate_detector.sv
// Recovers the divider rate code (00/01/10) from a square wave by timing its
// half-periods against tolerance windows; locks after MATCH_CNT agreeing samples.
module clk_rate_detector #(
    parameter int CLOCKFREQ   = 100_000_000,
    parameter int EXPECT_CLK0 = 10000,
    parameter int EXPECT_CLK1 = 8000,
    parameter int EXPECT_CLK2 = 10,
    parameter int TOL_SHIFT   = 4,
    parameter int MATCH_CNT   = 2
) (
    input  logic        iClk,
    input  logic        iRst,
    input  logic        iEn,
    input  logic        iSig,
    output logic [1:0]  oRate,
    output logic        oLock,
    output logic [31:0] oMeasure,
    output logic        oErrPulse,
    output logic        oTimeout
);

    localparam int HP0   = CLOCKFREQ / (2 * EXPECT_CLK0);
    localparam int HP1   = CLOCKFREQ / (2 * EXPECT_CLK1);
    localparam int HP2   = CLOCKFREQ / (2 * EXPECT_CLK2);
    localparam int HPMAX = (HP0 > HP1) ? ((HP0 > HP2) ? HP0 : HP2)
                                       : ((HP1 > HP2) ? HP1 : HP2);

    localparam logic [31:0] LO0     = 32'(HP0 - (HP0 >> TOL_SHIFT));
    localparam logic [31:0] HI0     = 32'(HP0 + (HP0 >> TOL_SHIFT));
    localparam logic [31:0] LO1     = 32'(HP1 - (HP1 >> TOL_SHIFT));
    localparam logic [31:0] HI1     = 32'(HP1 + (HP1 >> TOL_SHIFT));
    localparam logic [31:0] LO2     = 32'(HP2 - (HP2 >> TOL_SHIFT));
    localparam logic [31:0] HI2     = 32'(HP2 + (HP2 >> TOL_SHIFT));
    localparam logic [31:0] TIMEOUT = 32'(2 * HPMAX);
    localparam logic [3:0]  MATCH_N = 4'(MATCH_CNT);
    localparam logic [1:0]  CLS_NONE = 2'b11;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } state_t;

    logic        sync1_q, sync2_q, sync3_q;
    logic        edgePulse;
    logic [31:0] cnt_q;
    logic        prevValid_q;
    state_t      state_q;
    logic [1:0]  cand_q;
    logic [3:0]  matchCnt_q;
    logic [1:0]  rate_q;
    logic        lock_q;
    logic [31:0] measure_q;
    logic        errPulse_q;
    logic        timeout_q;

    logic [1:0]  measClass;
    logic [3:0]  nextMatch;
    logic        cntAtLimit;

    // The synchronizer keeps sampling while disabled so re-enabling never
    // manufactures a false edge.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
        end else begin
            sync1_q <= iSig;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
        end
    end

    assign edgePulse  = sync2_q ^ sync3_q;
    assign cntAtLimit = (cnt_q == TIMEOUT);

    // Later assignments win, so the lowest matching class takes priority.
    always_comb begin
        measClass = CLS_NONE;
        if (cnt_q >= LO2 && cnt_q <= HI2) measClass = 2'd2;
        if (cnt_q >= LO1 && cnt_q <= HI1) measClass = 2'd1;
        if (cnt_q >= LO0 && cnt_q <= HI0) measClass = 2'd0;
        nextMatch = 4'd1;
        if (measClass == cand_q)
            nextMatch = (matchCnt_q == 4'd15) ? 4'd15 : matchCnt_q + 4'd1;
    end

    always_ff @(posedge iClk) begin
        if (iRst || !iEn) begin
            cnt_q       <= '0;
            prevValid_q <= 1'b0;
            state_q     <= SEARCH;
            cand_q      <= CLS_NONE;
            matchCnt_q  <= '0;
            rate_q      <= CLS_NONE;
            lock_q      <= 1'b0;
            measure_q   <= '0;
            errPulse_q  <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            errPulse_q <= 1'b0;
            if (edgePulse) begin
                // Counter restarts at 1 so its value at the next edge is the distance.
                cnt_q     <= 32'd1;
                timeout_q <= 1'b0;
                if (!prevValid_q || cntAtLimit) begin
                    prevValid_q <= 1'b1;
                    if (cntAtLimit) begin
                        state_q    <= SEARCH;
                        rate_q     <= CLS_NONE;
                        lock_q     <= 1'b0;
                        cand_q     <= CLS_NONE;
                        matchCnt_q <= '0;
                    end
                end else begin
                    measure_q <= cnt_q;
                    case (state_q)
                        SEARCH: begin
                            if (measClass == CLS_NONE) begin
                                errPulse_q <= 1'b1;
                                cand_q     <= CLS_NONE;
                                matchCnt_q <= '0;
                            end else begin
                                cand_q     <= measClass;
                                matchCnt_q <= nextMatch;
                                if (nextMatch >= MATCH_N) begin
                                    state_q <= LOCKED;
                                    rate_q  <= measClass;
                                    lock_q  <= 1'b1;
                                end
                            end
                        end
                        LOCKED: begin
                            if (measClass != rate_q) begin
                                state_q    <= SEARCH;
                                rate_q     <= CLS_NONE;
                                lock_q     <= 1'b0;
                                cand_q     <= measClass;
                                matchCnt_q <= (measClass == CLS_NONE) ? 4'd0 : 4'd1;
                                errPulse_q <= (measClass == CLS_NONE);
                            end
                        end
                        default: state_q <= SEARCH;
                    endcase
                end
            end else if (cntAtLimit) begin
                if (!timeout_q) begin
                    timeout_q   <= 1'b1;
                    state_q     <= SEARCH;
                    rate_q      <= CLS_NONE;
                    lock_q      <= 1'b0;
                    prevValid_q <= 1'b0;
                    cand_q      <= CLS_NONE;
                    matchCnt_q  <= '0;
                end
            end else begin
                cnt_q <= cnt_q + 32'd1;
            end
        end
    end

    assign oRate     = rate_q;
    assign oLock     = lock_q;
    assign oMeasure  = measure_q;
    assign oErrPulse = errPulse_q;
    assign oTimeout  = timeout_q;

endmodule

// File: tb/tb_clk_rate_detector.sv
// Scoreboard bench for clk_rate_detector: the driver queues expected outputs per
// toggle and a monitor compares them at the cycle the detector reports them.
module tb_clk_rate_detector;

    // Scaled clock: HP0=500, HP1=625, HP2=5000, TIMEOUT=10000.
    localparam int TO_CYC = 10000;

    logic        iClk = 1'b0;
    logic        iRst;
    logic        iEn;
    logic        iSig;
    logic [1:0]  oRate;
    logic        oLock;
    logic [31:0] oMeasure;
    logic        oErrPulse;
    logic        oTimeout;

    int cyc = 0;
    int compared = 0;
    int mismatched = 0;

    typedef struct {
        int          cyc;
        logic [31:0] meas;
        logic [1:0]  rate;
        logic        lock;
        logic        err;
        logic        to;
        string       name;
    } exp_t;

    exp_t expQ[$];

    clk_rate_detector #(
        .CLOCKFREQ  (10_000_000),
        .EXPECT_CLK0(10000),
        .EXPECT_CLK1(8000),
        .EXPECT_CLK2(1000),
        .TOL_SHIFT  (4),
        .MATCH_CNT  (2)
    ) dut (
        .iClk     (iClk),
        .iRst     (iRst),
        .iEn      (iEn),
        .iSig     (iSig),
        .oRate    (oRate),
        .oLock    (oLock),
        .oMeasure (oMeasure),
        .oErrPulse(oErrPulse),
        .oTimeout (oTimeout)
    );

    always #5 iClk = ~iClk;

    always @(posedge iClk) cyc <= cyc + 1;

    task automatic pushExp(input int c, input logic [31:0] m, input logic [1:0] r,
                           input logic l, input logic e, input logic t, input string n);
        exp_t x;
        x.cyc  = c;
        x.meas = m;
        x.rate = r;
        x.lock = l;
        x.err  = e;
        x.to   = t;
        x.name = n;
        expQ.push_back(x);
    endtask

    // Toggles iSig 'half' cycles after the previous toggle; results appear 3 cycles later.
    task automatic applyStimulus(input int half, input logic [31:0] m, input logic [1:0] r,
                                 input logic l, input logic e, input string n);
        repeat (half) @(negedge iClk);
        iSig = ~iSig;
        pushExp(cyc + 3, m, r, l, e, 1'b0, n);
        if (e) pushExp(cyc + 4, m, r, l, 1'b0, 1'b0, {n, "_errEnd"});
    endtask

    task automatic checkOutput(input exp_t x);
        compared++;
        if (oMeasure !== x.meas || oRate !== x.rate || oLock !== x.lock ||
            oErrPulse !== x.err || oTimeout !== x.to) begin
            mismatched++;
            $display("[TB] FAIL %s cyc=%0d got meas=%0d rate=%b lock=%b err=%b to=%b want meas=%0d rate=%b lock=%b err=%b to=%b",
                     x.name, cyc, oMeasure, oRate, oLock, oErrPulse, oTimeout,
                     x.meas, x.rate, x.lock, x.err, x.to);
        end
    endtask

    // Monitor: pops every expectation whose cycle has arrived.
    initial begin
        exp_t x;
        forever begin
            @(negedge iClk);
            while (expQ.size() > 0 && expQ[0].cyc <= cyc) begin
                x = expQ.pop_front();
                if (x.cyc < cyc) begin
                    compared++;
                    mismatched++;
                    $display("[TB] FAIL %s skipped at cyc=%0d want cyc=%0d", x.name, cyc, x.cyc);
                end else begin
                    checkOutput(x);
                end
            end
        end
    end

    initial begin
        wait (cyc >= 80000);
        $display("[TB] FAIL watchdog expired at cyc=%0d with %0d checks pending", cyc, expQ.size());
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int t;
        iRst = 1'b1;
        iEn  = 1'b1;
        iSig = 1'b0;
        repeat (3) @(negedge iClk);

        // Outputs must stay at reset values while iSig toggles under reset.
        for (int i = 0; i < 4; i++) applyStimulus(7, 32'd0, 2'b11, 1'b0, 1'b0, "resetHold");
        repeat (5) @(negedge iClk);
        iRst = 1'b0;

        applyStimulus(20,  32'd0,   2'b11, 1'b0, 1'b0, "arm10k");
        applyStimulus(500, 32'd500, 2'b11, 1'b0, 1'b0, "first10k");
        applyStimulus(500, 32'd500, 2'b00, 1'b1, 1'b0, "lock10k");
        applyStimulus(500, 32'd500, 2'b00, 1'b1, 1'b0, "hold10k");

        applyStimulus(625, 32'd625, 2'b11, 1'b0, 1'b0, "unlock8k");
        applyStimulus(625, 32'd625, 2'b01, 1'b1, 1'b0, "lock8k");

        applyStimulus(550, 32'd550, 2'b11, 1'b0, 1'b1, "err550a");
        applyStimulus(550, 32'd550, 2'b11, 1'b0, 1'b1, "err550b");

        applyStimulus(469, 32'd469, 2'b11, 1'b0, 1'b0, "lo0Accept");
        applyStimulus(531, 32'd531, 2'b00, 1'b1, 1'b0, "hi0Accept");
        applyStimulus(468, 32'd468, 2'b11, 1'b0, 1'b1, "lo0Reject");
        applyStimulus(532, 32'd532, 2'b11, 1'b0, 1'b1, "hi0Reject");

        applyStimulus(4688, 32'd4688, 2'b11, 1'b0, 1'b0, "lo2Accept");
        applyStimulus(5312, 32'd5312, 2'b10, 1'b1, 1'b0, "hi2Accept");
        applyStimulus(4687, 32'd4687, 2'b11, 1'b0, 1'b1, "lo2Reject");
        applyStimulus(5313, 32'd5313, 2'b11, 1'b0, 1'b1, "hi2Reject");

        applyStimulus(500, 32'd500, 2'b11, 1'b0, 1'b0, "relockA");
        applyStimulus(500, 32'd500, 2'b00, 1'b1, 1'b0, "relockB");
        t = cyc;
        pushExp(t + 2 + TO_CYC, 32'd500, 2'b00, 1'b1, 1'b0, 1'b0, "preTimeout");
        pushExp(t + 3 + TO_CYC, 32'd500, 2'b11, 1'b0, 1'b0, 1'b1, "timeout");
        applyStimulus(TO_CYC + 100, 32'd500, 2'b11, 1'b0, 1'b0, "timeoutClear");
        applyStimulus(500, 32'd500, 2'b11, 1'b0, 1'b0, "postTimeoutA");
        applyStimulus(500, 32'd500, 2'b00, 1'b1, 1'b0, "postTimeoutB");
        applyStimulus(500, 32'd500, 2'b00, 1'b1, 1'b0, "holdLock");

        repeat (100) @(negedge iClk);
        pushExp(cyc + 1, 32'd0, 2'b11, 1'b0, 1'b0, 1'b0, "midLockReset");
        iRst = 1'b1;
        @(negedge iClk);
        iRst = 1'b0;
        applyStimulus(200, 32'd0,   2'b11, 1'b0, 1'b0, "rstArm");
        applyStimulus(500, 32'd500, 2'b11, 1'b0, 1'b0, "rstFirst");
        applyStimulus(500, 32'd500, 2'b00, 1'b1, 1'b0, "rstLock");

        repeat (50) @(negedge iClk);
        pushExp(cyc + 1, 32'd0, 2'b11, 1'b0, 1'b0, 1'b0, "enLowClear");
        iEn = 1'b0;
        repeat (50) @(negedge iClk);
        iSig = ~iSig;
        pushExp(cyc + 3, 32'd0, 2'b11, 1'b0, 1'b0, 1'b0, "enLowToggle");
        repeat (50) @(negedge iClk);
        iEn = 1'b1;
        applyStimulus(300, 32'd0,   2'b11, 1'b0, 1'b0, "enArm");
        applyStimulus(500, 32'd500, 2'b11, 1'b0, 1'b0, "enFirst");

        for (int i = 0; i < 20 && expQ.size() > 0; i++) @(negedge iClk);
        while (expQ.size() > 0) begin
            exp_t x;
            x = expQ.pop_front();
            compared++;
            mismatched++;
            $display("[TB] FAIL %s never reached, got cyc=%0d want cyc=%0d", x.name, cyc, x.cyc);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/clk_rate_detector.md
Name: clk_rate_detector

Overview:
- Measures a square wave produced by the programmable clock divider and recovers which rate code generated it: 00, 01 or 10 (11 = unknown).
- Used as the loop-back checker on the UART_SEG_PWM_LED board. Drives the seven-segment "rate" digit and the lock LED.
- Classification uses a half-period measured against tolerance windows around each nominal rate.

Parameters:
- CLOCKFREQ, 100_000_000: system clock in Hz.
- EXPECT_CLK0, 10000: frequency in Hz of rate code 00.
- EXPECT_CLK1, 8000: frequency in Hz of rate code 01.
- EXPECT_CLK2, 10: frequency in Hz of rate code 10.
- TOL_SHIFT, 4: tolerance = nominal half-period >> TOL_SHIFT (1/16).
- MATCH_CNT, 2: consecutive same-class measurements required to lock (range 1..15).

Ports:
- iClk  input  1  system clock, 100 MHz.
- iRst  input  1  synchronous reset, active-high.
- iEn  input  1  detector enable; when low, all state is held at reset values except the synchronizer.
- iSig  input  1  asynchronous square wave under test.
- oRate  output  2  recovered rate code; 2'b11 = unknown.
- oLock  output  1  high while oRate is valid.
- oMeasure  output  32  most recent half-period in clock cycles.
- oErrPulse  output  1  one-cycle pulse when a measurement fits no window.
- oTimeout  output  1  high while no edge has been seen for TIMEOUT cycles.

Behaviour:
- Derived constants:
  - HPk = CLOCKFREQ/(2*EXPECT_CLKk). Defaults: HP0=5000, HP1=6250, HP2=5_000_000.
  - Window k = [HPk - (HPk>>TOL_SHIFT), HPk + (HPk>>TOL_SHIFT)], inclusive. Defaults: 4688..5312, 5860..6640, 4687500..5312500.
  - TIMEOUT = 2*max(HP0,HP1,HP2).
  - Windows are non-overlapping. If several match, the lowest k wins.
- Reset (iRst=1 at a clock edge):
  - oRate=2'b11, oLock=0, oMeasure=0, oErrPulse=0, oTimeout=0.
  - Synchronizer flops = 0, counter = 0, state = SEARCH, no previous edge, candidate = 11, match count = 0.
  - Reset mid-lock takes effect on that same edge.
- Input path:
  - Two-flop synchronizer, then a third flop.
  - Edge pulse = stage2 XOR stage3; both rising and falling edges count.
  - Latency: an iSig transition produces the edge pulse 3 clock cycles later.
- Counter:
  - Increments every enabled cycle and saturates at TIMEOUT.
  - On an edge pulse it restarts so that the measured value P equals the cycle distance between consecutive edge pulses.
- The first edge after reset, after iEn falls, or after a timeout only arms the measurement ("previous edge" flag). It produces no classification.
- Measurement (edge pulse with previous edge valid):
  - oMeasure <= P on the next clock.
  - P is classified as class k, or as none.
  - All output updates occur 1 cycle after the edge pulse.
- State SEARCH (oLock=0, oRate=11):
  - class == candidate: match count +1.
  - Otherwise: candidate = class, count = 1.
  - Class none: oErrPulse=1 and candidate cleared.
  - Count reaching MATCH_CNT: go to LOCKED, oRate=candidate, oLock=1.
- State LOCKED:
  - Measurement of the same class: no change.
  - Any other class, or none: back to SEARCH, oLock=0, oRate=11, candidate = new class, count = 1 (0 if none).
  - Class none also pulses oErrPulse.
- Timeout, when the counter reaches TIMEOUT:
  - oTimeout=1, state = SEARCH, oRate=11, oLock=0, previous edge cleared, candidate cleared.
  - oTimeout stays high until the next edge pulse. That edge clears it, arms the measurement, and does not classify.
- Simultaneous timeout and edge in the same cycle: the edge wins, and it is treated as the first edge after a timeout.
- iEn=0: synchronous clear as for reset, except the synchronizer keeps sampling. When iEn rises, the next edge only arms.
- oErrPulse is never high for more than one cycle per measurement.

Test Plan:
- Reset with iSig toggling: oRate=11, oLock=0, oMeasure=0 throughout. Release reset, drive 10 kHz → after 3 edges oLock=1, oRate=00, oMeasure=5000.
- 8 kHz after a locked 10 kHz: the first 6250 measurement gives oLock=0, oRate=11. After the second 6250 measurement: oRate=01, oLock=1.
- Half-periods of 5500 cycles: oErrPulse is one cycle per edge, oLock stays 0. Boundaries 4688 and 5312 are accepted; 4687 and 5313 are rejected.
- Bench override EXPECT_CLK2=1000 (HP2=50000), iSig held constant after a lock → oTimeout=1 exactly TIMEOUT cycles after the last edge pulse, oRate=11. The next edge clears oTimeout without locking.
- iRst asserted for 1 cycle while locked at 00 → all outputs return to reset values on the next clock. Relock needs 3 fresh edges.
- iEn low for 100 cycles during a lock → outputs cleared. After iEn rises, the first edge does not update oMeasure.
